ex_mem_skid: RTL and testbench

Parametrised EX/MEM pipeline stage that replaces the bare flop-per-field pipeline register between execute and memory. It carries the B operand, the ALU result bus, the destination select and the load/store flags. It adds a valid/ready handshake with a two-entry skid buffer, so backpressure from the memory stage never forms a combinational path back into execute. It also adds a synchronous flush for branch/exception squash and a saturating stall counter for performance monitoring.

---
 rtl/ex_mem_pkg.sv | 23 ++
 rtl/pipe_reg.sv | 26 ++
 rtl/ex_mem_skid.sv | 138 +++++++++++++
 tb/tb_ex_mem_skid.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types and default widths for the EX/MEM skid-buffered pipeline stage.
package ex_mem_pkg;

  localparam int EX_MEM_DATA_W = 32;
  localparam int EX_MEM_SEL_W  = 32;
  localparam int EX_MEM_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } ex_mem_state_e;

  // One pipeline entry at the default widths; the stage re-declares it with its own parameters.
  typedef struct packed {
    logic [EX_MEM_DATA_W-1:0] boperand;
    logic [EX_MEM_DATA_W-1:0] dbus;
    logic [EX_MEM_SEL_W-1:0]  dsel;
    logic                     store;
    logic                     load;
  } ex_mem_entry_t;

endpackage

// File: rtl/pipe_reg.sv
// Parametrised-width enabled register, asynchronously cleared by an active-high reset.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // the contents are reset too, because downstream sees zeros straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline stage: valid/ready handshake with a two-entry skid buffer (M drives outputs,
// S absorbs one overflow), synchronous flush and a saturating stall counter.
module ex_mem_skid
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = EX_MEM_DATA_W,
  parameter int SEL_W  = EX_MEM_SEL_W,
  parameter int CNT_W  = EX_MEM_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_boperand,
  input  logic [DATA_W-1:0] in_dbus,
  input  logic [SEL_W-1:0]  in_dsel,
  input  logic              in_store,
  input  logic              in_load,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_boperand,
  output logic [DATA_W-1:0] out_dbus,
  output logic [SEL_W-1:0]  out_dsel,
  output logic              out_store,
  output logic              out_load,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] boperand;
    logic [DATA_W-1:0] dbus;
    logic [SEL_W-1:0]  dsel;
    logic              store;
    logic              load;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  ex_mem_state_e    state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  entry_t in_entry;
  entry_t m_q, m_d;
  entry_t s_q;
  logic   m_en, s_en;
  logic   acc, fire;

  assign in_entry = '{boperand: in_boperand, dbus: in_dbus, dsel: in_dsel,
                      store: in_store, load: in_load};

  // Handshake flags come only from the state register, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign acc       = in_valid & in_ready & ~flush;
  assign fire      = out_valid & out_ready;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    m_en    = 1'b0;
    m_d     = in_entry;
    s_en    = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          m_en    = 1'b1;
          state_d = ST_HALF;
        end
      end
      ST_HALF: begin
        if (acc && fire) begin
          m_en = 1'b1;
        end else if (acc) begin
          s_en    = 1'b1;
          state_d = ST_FULL;
        end else if (fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (fire) begin
          m_en    = 1'b1;
          m_d     = s_q;
          state_d = ST_HALF;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Squash wins over everything; held entries become don't-care once the state is EMPTY.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  pipe_reg #(.W(ENTRY_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (m_en),
    .d     (m_d),
    .q     (m_q)
  );

  pipe_reg #(.W(ENTRY_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (s_en),
    .d     (in_entry),
    .q     (s_q)
  );

  assign out_boperand = m_q.boperand;
  assign out_dbus     = m_q.dbus;
  assign out_dsel     = m_q.dsel;
  // Memory must never see an access from an invalid slot.
  assign out_store    = m_q.store & out_valid;
  assign out_load     = m_q.load  & out_valid;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed self-checking bench for ex_mem_skid (CNT_W=4 so saturation is reachable quickly).
module tb_ex_mem_skid;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_boperand;
  logic [DATA_W-1:0] in_dbus;
  logic [SEL_W-1:0]  in_dsel;
  logic              in_store;
  logic              in_load;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_boperand;
  logic [DATA_W-1:0] out_dbus;
  logic [SEL_W-1:0]  out_dsel;
  logic              out_store;
  logic              out_load;
  logic [CNT_W-1:0]  stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] got_q[$];

  ex_mem_skid #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_boperand  (in_boperand),
    .in_dbus      (in_dbus),
    .in_dsel      (in_dsel),
    .in_store     (in_store),
    .in_load      (in_load),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_boperand (out_boperand),
    .out_dbus     (out_dbus),
    .out_dsel     (out_dsel),
    .out_store    (out_store),
    .out_load     (out_load),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // Record every delivered entry mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) got_q.push_back(out_dbus);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] dbus,
                       input logic st, input logic ld, input logic rdy);
    in_valid    = v;
    in_dbus     = dbus;
    in_boperand = ~dbus;
    in_dsel     = 32'h1 << dbus[4:0];
    in_store    = st;
    in_load     = ld;
    out_ready   = rdy;
  endtask

  task automatic check_order(input string tag, input logic [DATA_W-1:0] exp[$]);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_%0d", tag, i), 64'(got_q[i]), 64'(exp[i]));
    end
    got_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] exp_q[$];

    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_dbus",  64'(out_dbus),  64'd0);
    check("rst_out_store", 64'(out_store), 64'd0);
    check("rst_stall",     64'(stall_cnt), 64'd0);
    reset = 1'b0;
    step();

    // Streaming: 8 back-to-back entries, out_ready held high.
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DATA_W'(32'h1000 + i), 1'b0, 1'b0, 1'b1);
      exp_q.push_back(DATA_W'(32'h1000 + i));
      step();
      if (i == 0) begin
        check("stream_first_valid", 64'(out_valid), 64'd1);
        check("stream_first_dbus",  64'(out_dbus),  64'h1000);
      end
      check($sformatf("stream_in_ready_%0d", i), 64'(in_ready), 64'd1);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step();
    check("stream_drained", 64'(out_valid), 64'd0);
    check_order("stream_order", exp_q);
    check("stream_stall", 64'(stall_cnt), 64'd0);

    // Backpressure: 0xA accepted, then 3 stalled cycles offering 0xB, 0xC, 0xC.
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    step();
    check("bp_half_valid", 64'(out_valid), 64'd1);
    check("bp_half_ready", 64'(in_ready),  64'd1);
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    step();
    check("bp_full_ready_s2", 64'(in_ready), 64'd0);
    check("bp_full_dbus",     64'(out_dbus), 64'hA);
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    step();
    check("bp_full_ready_s3", 64'(in_ready), 64'd0);
    step();
    check("bp_stall_held", 64'(stall_cnt), 64'd3);
    check("bp_dbus_held",  64'(out_dbus),  64'hA);
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
    step();
    check("bp_rel_dbus", 64'(out_dbus), 64'hB);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step();
    check("bp_rel_empty", 64'(out_valid), 64'd0);
    exp_q.delete();
    exp_q.push_back(32'hA);
    exp_q.push_back(32'hB);
    exp_q.push_back(32'hC);
    check_order("bp_order", exp_q);
    check("bp_stall_final", 64'(stall_cnt), 64'd3);

    // Flush from FULL (0x11, 0x22) while 0x33 is offered; stall +1 filling, +1 flush cycle.
    drive(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    step();
    check("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
    step();
    flush = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_store", 64'(out_store), 64'd0);
    check("fl_ready", 64'(in_ready),  64'd1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    check("fl_nothing_out", 64'(got_q.size()), 64'd0);
    got_q.delete();
    check("fl_stall_kept", 64'(stall_cnt), 64'd5);

    // Store gating: 0xDEAD/0x40 held one stalled cycle, then delivered.
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    in_boperand = 32'hDEAD;
    step();
    check("st_store_on", 64'(out_store),    64'd1);
    check("st_load_off", 64'(out_load),     64'd0);
    check("st_boperand", 64'(out_boperand), 64'hDEAD);
    check("st_dbus",     64'(out_dbus),     64'h40);
    check("st_dsel",     64'(out_dsel),     64'h1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();
    check("st_store_held", 64'(out_store), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step();
    check("st_store_off", 64'(out_store), 64'd0);
    check("st_stall",     64'(stall_cnt), 64'd6);
    drive(1'b1, 32'h44, 1'b0, 1'b1, 1'b1);
    step();
    check("ld_load_on", 64'(out_load), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step();
    check("ld_load_off", 64'(out_load), 64'd0);
    got_q.delete();

    // Async reset mid-cycle while FULL.
    drive(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h66, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("ar_full", 64'(in_ready), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_store", 64'(out_store), 64'd0);
    check("ar_load",  64'(out_load),  64'd0);
    check("ar_ready", 64'(in_ready),  64'd1);
    check("ar_stall", 64'(stall_cnt), 64'd0);
    check("ar_dbus",  64'(out_dbus),  64'd0);
    #3;
    reset = 1'b0;
    step();

    // Saturation: one entry held with out_ready low for 20 cycles.
    drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) check("sat_14", 64'(stall_cnt), 64'd14);
      if (i == 15) check("sat_15", 64'(stall_cnt), 64'd15);
    end
    check("sat_20", 64'(stall_cnt), 64'd15);
    check("sat_dbus", 64'(out_dbus), 64'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
